// File: rtl/evaluation_sequencer.sv
// evaluation_sequencer
//   Control stage in front of the per-output error accumulator. Applies up to
//   16 input patterns to the chromosome, CYCLES_PER_SEQUENCE cycles each. It
//   drives the accumulator's process/keep controls and then holds the sums
//   until the consumer acknowledges them.
//   Optional feature macro: SEQUENCER_ABORT_EN (adds iAbort to cancel a run).
module evaluation_sequencer #(
    parameter int unsigned CYCLES_PER_SEQUENCE = 16,
    parameter int unsigned NUM_SEQUENCES       = 16
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iStart,
    input  logic             iResultAck,
`ifdef SEQUENCER_ABORT_EN
    input  logic             iAbort,
`endif
    input  logic [15:0][7:0] iInputPatterns,
    output logic [7:0]       oChromosomeInput,
    output logic             oProcessing,
    output logic             oKeepResult,
    output logic [3:0]       oCurrentSequence,
    output logic [31:0]      oClockCycleCounter,
    output logic             oBusy,
    output logic             oDone,
    output logic [15:0]      oRunCount
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    // Terminal values; both counters are compared for equality only.
    localparam logic [31:0] LAST_CYCLE = 32'(CYCLES_PER_SEQUENCE - 1);
    localparam logic [3:0]  LAST_SEQ   = 4'(NUM_SEQUENCES - 1);

    state_t state;
    logic   abortReq;

`ifdef SEQUENCER_ABORT_EN
    assign abortReq = iAbort;
`else
    assign abortReq = 1'b0;
`endif

    // Pattern mux follows the registered index with no extra latency.
    assign oChromosomeInput = iInputPatterns[oCurrentSequence];

    // Sequencer FSM. Every control output is registered alongside the state.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state              <= IDLE;
            oProcessing        <= 1'b0;
            oKeepResult        <= 1'b0;
            oCurrentSequence   <= 4'd0;
            oClockCycleCounter <= 32'd0;
            oBusy              <= 1'b0;
            oDone              <= 1'b0;
            oRunCount          <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Keep and process both low: the accumulator clears here.
                    oProcessing        <= 1'b0;
                    oKeepResult        <= 1'b0;
                    oCurrentSequence   <= 4'd0;
                    oClockCycleCounter <= 32'd0;
                    oBusy              <= 1'b0;
                    oDone              <= 1'b0;
                    if (iStart) begin
                        state       <= RUN;
                        oProcessing <= 1'b1;
                        oBusy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (abortReq) begin
                        // Discard the partial sums: go straight to the clearing state.
                        state              <= IDLE;
                        oProcessing        <= 1'b0;
                        oBusy              <= 1'b0;
                        oCurrentSequence   <= 4'd0;
                        oClockCycleCounter <= 32'd0;
                    end else if (oClockCycleCounter == LAST_CYCLE) begin
                        // Counter wrap and pattern change happen on the same edge.
                        oClockCycleCounter <= 32'd0;
                        if (oCurrentSequence == LAST_SEQ) begin
                            state            <= HOLD;
                            oProcessing      <= 1'b0;
                            oBusy            <= 1'b0;
                            oKeepResult      <= 1'b1;
                            oDone            <= 1'b1;
                            oCurrentSequence <= 4'd0;
                            oRunCount        <= oRunCount + 16'd1;
                        end else begin
                            oCurrentSequence <= oCurrentSequence + 4'd1;
                        end
                    end else begin
                        oClockCycleCounter <= oClockCycleCounter + 32'd1;
                    end
                end
                HOLD: begin
                    // Start is ignored here, so IDLE always gets at least one cycle.
                    if (iResultAck) begin
                        state       <= IDLE;
                        oKeepResult <= 1'b0;
                        oDone       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evaluation_sequencer.sv
// Bench for evaluation_sequencer: two instances (4x3 and 1x16), an abstract
// run-cycle model checked every cycle, plus directed literal checks.
module tb_evaluation_sequencer;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            start, ack, abortS;
    logic [15:0][7:0]      patA, patB;
    logic [1:0][7:0]       chromO;
    logic [1:0]            procO, keepO, busyO, doneO;
    logic [1:0][3:0]       seqO;
    logic [1:0][31:0]      cntO;
    logic [1:0][15:0]      runO;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    evaluation_sequencer #(.CYCLES_PER_SEQUENCE(4), .NUM_SEQUENCES(3)) dutA (
        .iClock(clk), .iReset(rst), .iStart(start[0]), .iResultAck(ack[0]),
`ifdef SEQUENCER_ABORT_EN
        .iAbort(abortS[0]),
`endif
        .iInputPatterns(patA), .oChromosomeInput(chromO[0]),
        .oProcessing(procO[0]), .oKeepResult(keepO[0]), .oCurrentSequence(seqO[0]),
        .oClockCycleCounter(cntO[0]), .oBusy(busyO[0]), .oDone(doneO[0]),
        .oRunCount(runO[0]));

    evaluation_sequencer #(.CYCLES_PER_SEQUENCE(1), .NUM_SEQUENCES(16)) dutB (
        .iClock(clk), .iReset(rst), .iStart(start[1]), .iResultAck(ack[1]),
`ifdef SEQUENCER_ABORT_EN
        .iAbort(abortS[1]),
`endif
        .iInputPatterns(patB), .oChromosomeInput(chromO[1]),
        .oProcessing(procO[1]), .oKeepResult(keepO[1]), .oCurrentSequence(seqO[1]),
        .oClockCycleCounter(cntO[1]), .oBusy(busyO[1]), .oDone(doneO[1]),
        .oRunCount(runO[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Abstract model: a run is just k = 0..CPS*NS-1 elapsed cycles.
    int cpsM [2] = '{4, 1};
    int nsM  [2] = '{3, 16};
    int phase[2];   // 0 idle, 1 run, 2 hold
    int kM   [2];
    int rcM  [2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                phase[i] = 0; kM[i] = 0; rcM[i] = 0;
            end else begin
                case (phase[i])
                    0: if (start[i]) begin phase[i] = 1; kM[i] = 0; end
                    1: begin
`ifdef SEQUENCER_ABORT_EN
                        if (abortS[i]) phase[i] = 0;
                        else
`endif
                        if (kM[i] == cpsM[i] * nsM[i] - 1) begin
                            phase[i] = 2; rcM[i] = (rcM[i] + 1) % 65536;
                        end else kM[i]++;
                    end
                    default: if (ack[i]) phase[i] = 0;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                int es, ec;
                logic [7:0] ep;
                es = (phase[i] == 1) ? kM[i] / cpsM[i] : 0;
                ec = (phase[i] == 1) ? kM[i] % cpsM[i] : 0;
                ep = (i == 0) ? patA[es] : patB[es];
                chk($sformatf("model_proc%0d", i), 32'(procO[i]), 32'(phase[i] == 1));
                chk($sformatf("model_busy%0d", i), 32'(busyO[i]), 32'(phase[i] == 1));
                chk($sformatf("model_keep%0d", i), 32'(keepO[i]), 32'(phase[i] == 2));
                chk($sformatf("model_done%0d", i), 32'(doneO[i]), 32'(phase[i] == 2));
                chk($sformatf("model_seq%0d", i), 32'(seqO[i]), 32'(es));
                chk($sformatf("model_cnt%0d", i), cntO[i], 32'(ec));
                chk($sformatf("model_chrom%0d", i), 32'(chromO[i]), 32'(ep));
                chk($sformatf("model_runs%0d", i), 32'(runO[i]), 32'(rcM[i]));
            end
        end
    end

    // Traces of what happened while processing.
    int   procCntA = 0;
    int   seqTr[$];
    int   cntTr[$];
    int   chromTr[$];
    always @(negedge clk) begin
        if (!rst && procO[0]) begin
            procCntA++; seqTr.push_back(int'(seqO[0])); cntTr.push_back(int'(cntO[0]));
        end
        if (!rst && procO[1]) chromTr.push_back(int'(chromO[1]));
    end

    task automatic tick();
        @(negedge clk); #2;
    endtask

    task automatic waitDone(input int idx, input string name);
        bit got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (doneO[idx]) begin got = 1'b1; break; end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    initial begin
        int expSeq [12] = '{0,0,0,0,1,1,1,1,2,2,2,2};
        rst = 1'b1; start = '0; ack = '0; abortS = '0;
        for (int k = 0; k < 16; k++) begin
            patA[k] = 8'(8'hA0 + k);
            patB[k] = 8'(k * 17);
        end
        #1;
        chk("rst_proc", 32'(procO[0]), 32'd0);
        chk("rst_keep", 32'(keepO[0]), 32'd0);
        chk("rst_runs", 32'(runO[0]), 32'd0);
        chk("rst_chrom", 32'(chromO[0]), 32'hA0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Run on 4x3, with a stray start in the middle.
        procCntA = 0; seqTr.delete(); cntTr.delete();
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        chk("start_proc", 32'(procO[0]), 32'd1);
        tick(); tick(); tick(); tick();
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        waitDone(0, "run1_done");
        chk("run1_proc_cycles", 32'(procCntA), 32'd12);
        chk("run1_trace_len", 32'(seqTr.size()), 32'd12);
        for (int i = 0; i < 12 && i < seqTr.size(); i++) begin
            chk($sformatf("run1_seq[%0d]", i), 32'(seqTr[i]), 32'(expSeq[i]));
            chk($sformatf("run1_cnt[%0d]", i), 32'(cntTr[i]), 32'(i % 4));
        end
        chk("run1_runs", 32'(runO[0]), 32'd1);
        chk("run1_keep", 32'(keepO[0]), 32'd1);

        // Start in HOLD is ignored.
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        chk("hold_start_done", 32'(doneO[0]), 32'd1);
        chk("hold_start_runs", 32'(runO[0]), 32'd1);

        // Ack with start together: one IDLE cycle, then a new start is accepted.
        ack[0] = 1'b1; start[0] = 1'b1; tick(); ack[0] = 1'b0; start[0] = 1'b0;
        chk("ackstart_proc", 32'(procO[0]), 32'd0);
        chk("ackstart_keep", 32'(keepO[0]), 32'd0);
        chk("ackstart_done", 32'(doneO[0]), 32'd0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        chk("restart_proc", 32'(procO[0]), 32'd1);

        // Async reset mid-run at index 1, counter 2.
        repeat (6) tick();
        chk("mid_seq", 32'(seqO[0]), 32'd1);
        chk("mid_cnt", cntO[0], 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("arst_proc", 32'(procO[0]), 32'd0);
        chk("arst_busy", 32'(busyO[0]), 32'd0);
        chk("arst_seq", 32'(seqO[0]), 32'd0);
        chk("arst_cnt", cntO[0], 32'd0);
        chk("arst_runs", 32'(runO[0]), 32'd0);
        chk("arst_chrom", 32'(chromO[0]), 32'hA0);
        tick(); rst = 1'b0; tick();
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        chk("post_rst_seq", 32'(seqO[0]), 32'd0);
        chk("post_rst_proc", 32'(procO[0]), 32'd1);
        waitDone(0, "run2_done");
        chk("run2_runs", 32'(runO[0]), 32'd1);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;

        // 1x16: chromosome steps through k*17 on consecutive cycles.
        chromTr.delete();
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        waitDone(1, "runB_done");
        chk("runB_len", 32'(chromTr.size()), 32'd16);
        for (int i = 0; i < 16 && i < chromTr.size(); i++)
            chk($sformatf("runB_chrom[%0d]", i), 32'(chromTr[i]), 32'(i * 17));
        chk("runB_runs", 32'(runO[1]), 32'd1);
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;

`ifdef SEQUENCER_ABORT_EN
        // Abort in the last run cycle wins over the transition to HOLD.
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        repeat (11) tick();
        chk("abort_last_seq", 32'(seqO[0]), 32'd2);
        chk("abort_last_cnt", cntO[0], 32'd3);
        abortS[0] = 1'b1; tick(); abortS[0] = 1'b0;
        chk("abort_proc", 32'(procO[0]), 32'd0);
        chk("abort_runs", 32'(runO[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", 32'(doneO[0]), 32'd0);
            tick();
        end
`endif

        tick();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", nChecks, nPass);
        $fatal(1);
    end

endmodule
